// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte receiver: FSM states, counter sizing
// and the majority vote used on the oversampled line.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    function automatic int cnt_width(input int clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

    function automatic int mid_bit(input int clks);
        return clks / 2;
    endfunction

    function automatic logic majority3(input logic [2:0] taps);
        return (taps[0] & taps[1]) | (taps[0] & taps[2]) | (taps[1] & taps[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Brings the raw serial line into the clk domain, votes over three samples
// and flags a 1->0 transition of the voted line.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic n_reset,
    input  logic rx_pin,
    output logic rx_bit,
    output logic rx_fall
);

    logic       sync_p0;
    logic       sync_p1;
    logic [2:0] taps_p2;
    logic       vld_p0;
    logic       vld_p1;
    logic [2:0] vld_p2;
    logic       rx_prev;
    logic       armed;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            taps_p2 <= 3'b111;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 3'b000;
            rx_prev <= 1'b1;
            armed   <= 1'b0;
        end else begin
            // p0/p1: metastability guard; p2: vote window
            sync_p0 <= rx_pin;
            sync_p1 <= sync_p0;
            taps_p2 <= {taps_p2[1:0], sync_p1};
            vld_p0  <= 1'b1;
            vld_p1  <= vld_p0;
            vld_p2  <= {vld_p2[1:0], vld_p1};
            rx_prev <= rx_bit;
            // The reset-time ones in the chain are not real samples, so a start
            // edge only counts once a genuine high level has been voted.
            if ((&vld_p2) && rx_bit) begin
                armed <= 1'b1;
            end
        end
    end

    assign rx_bit  = majority3(taps_p2);
    assign rx_fall = armed && rx_prev && !rx_bit;

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver with a single-entry holding register on a valid/ready
// interface; never stalls the line, drops and flags bytes it cannot hold.
module uart_byte_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 417,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 uart_rx_pin,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 busy,
    output logic                 framing_err,
    output logic                 overrun_err
);

    localparam int               CNT_W    = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(mid_bit(CLKS_PER_BIT));
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

    logic                 rx_bit;
    logic                 rx_fall;
    rx_state_t            state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [2:0]           bit_idx, idx_nxt;
    logic [DATA_BITS-1:0] shift_reg, shift_nxt;
    logic                 byte_done;
    logic                 frame_bad;

    uart_rx_sync u_sync (
        .clk     (clk),
        .n_reset (n_reset),
        .rx_pin  (uart_rx_pin),
        .rx_bit  (rx_bit),
        .rx_fall (rx_fall)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= idx_nxt;
            shift_reg <= shift_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        idx_nxt   = bit_idx;
        shift_nxt = shift_reg;
        byte_done = 1'b0;
        frame_bad = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (rx_fall) begin
                    state_nxt = START;
                end
            end
            START: begin
                // Clearing the counter here puts every later sample at mid-bit.
                if (cnt == CNT_MID) begin
                    cnt_nxt = '0;
                    if (rx_bit) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DATA;
                        idx_nxt   = '0;
                    end
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    shift_nxt = {rx_bit, shift_reg[DATA_BITS-1:1]};
                    idx_nxt   = bit_idx + 3'd1;
                    if (bit_idx == IDX_LAST) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    byte_done = rx_bit;
                    frame_bad = !rx_bit;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            data        <= '0;
            data_valid  <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            framing_err <= frame_bad;
            overrun_err <= byte_done && data_valid && !data_ready;
            if (byte_done && (!data_valid || data_ready)) begin
                data       <= shift_reg;
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Bench for uart_byte_receiver: drives serial frames and compares delivered
// bytes and error pulses with a frame-level expectation model.
module tb_uart_byte_receiver;

    localparam int CPB = 16;
    localparam int DB  = 8;

    logic          clk = 1'b0;
    logic          n_reset = 1'b0;
    logic          uart_rx_pin = 1'b1;
    logic          data_ready = 1'b1;
    logic [DB-1:0] data;
    logic          data_valid;
    logic          busy;
    logic          framing_err;
    logic          overrun_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] acc_q[$];
    int vhi_cnt = 0, vlo_cnt = 0, busy_cnt = 0, fr_cnt = 0, ov_cnt = 0, rise_cyc = -1;
    logic vprev = 1'b0;

    uart_byte_receiver #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .uart_rx_pin (uart_rx_pin),
        .data        (data),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .busy        (busy),
        .framing_err (framing_err),
        .overrun_err (overrun_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Observe the interface mid-cycle; a handshake seen here completes on the next edge.
    always @(negedge clk) begin
        if (n_reset) begin
            if (data_valid && data_ready) acc_q.push_back(data);
            if (data_valid) vhi_cnt++; else vlo_cnt++;
            if (data_valid && !vprev) rise_cyc = cyc;
            if (busy) busy_cnt++;
            if (framing_err) fr_cnt++;
            if (overrun_err) ov_cnt++;
        end
        vprev = data_valid;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(posedge clk);
        #1;
        uart_rx_pin = 1'b0;
        idle(CPB - 1);
        for (int i = 0; i < DB; i++) begin
            uart_rx_pin = b[i];
            idle(CPB);
        end
        uart_rx_pin = stop_bit;
        idle(CPB);
        uart_rx_pin = 1'b1;
    endtask

    task automatic test_reset;
        int b0;
        n_reset = 1'b0;
        uart_rx_pin = 1'b0;
        idle(3);
        checks++; if (data !== 8'h00) begin failures++; $display("FAIL reset_data got=%0h want=0", data); end
        checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b want=0", data_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b want=0", busy); end
        checks++; if (framing_err !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%0b want=0", framing_err); end
        checks++; if (overrun_err !== 1'b0) begin failures++; $display("FAIL reset_oerr got=%0b want=0", overrun_err); end
        b0 = busy_cnt;
        n_reset = 1'b1;
        idle(60);
        checks++; if (busy_cnt - b0 !== 0) begin failures++; $display("FAIL low_out_of_reset busy_cycles got=%0d want=0", busy_cnt - b0); end
        uart_rx_pin = 1'b1;
        idle(20);
    endtask

    task automatic test_single;
        int a0 = acc_q.size(), v0 = vhi_cnt, f0 = fr_cnt, o0 = ov_cnt;
        data_ready = 1'b1;
        send_frame(8'hA5, 1'b1);
        idle(10);
        checks++; if (acc_q.size() - a0 !== 1) begin failures++; $display("FAIL single_count got=%0d want=1", acc_q.size() - a0); end
        else begin
            checks++; if (acc_q[a0] !== 8'hA5) begin failures++; $display("FAIL single_data got=%0h want=a5", acc_q[a0]); end
        end
        checks++; if (vhi_cnt - v0 !== 1) begin failures++; $display("FAIL single_valid_len got=%0d want=1", vhi_cnt - v0); end
        checks++; if ((fr_cnt - f0) + (ov_cnt - o0) !== 0) begin failures++; $display("FAIL single_errs got=%0d want=0", (fr_cnt - f0) + (ov_cnt - o0)); end
    endtask

    task automatic test_glitch;
        int a0 = acc_q.size(), b0 = busy_cnt, f0 = fr_cnt, o0 = ov_cnt;
        uart_rx_pin = 1'b0;
        idle(4);
        uart_rx_pin = 1'b1;
        idle(30);
        checks++; if (acc_q.size() - a0 !== 0) begin failures++; $display("FAIL glitch_data got=%0d want=0", acc_q.size() - a0); end
        checks++; if ((fr_cnt - f0) + (ov_cnt - o0) !== 0) begin failures++; $display("FAIL glitch_errs got=%0d want=0", (fr_cnt - f0) + (ov_cnt - o0)); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy got=%0b want=0", busy); end
        checks++; if ((busy_cnt - b0) < 1 || (busy_cnt - b0) > 10) begin failures++; $display("FAIL glitch_busy_len got=%0d want=1..10", busy_cnt - b0); end
    endtask

    task automatic test_framing;
        int a0 = acc_q.size(), f0 = fr_cnt;
        send_frame(8'h3C, 1'b0);
        idle(10);
        checks++; if (fr_cnt - f0 !== 1) begin failures++; $display("FAIL framing_pulse got=%0d want=1", fr_cnt - f0); end
        checks++; if (acc_q.size() - a0 !== 0) begin failures++; $display("FAIL framing_nodata got=%0d want=0", acc_q.size() - a0); end
        send_frame(8'h81, 1'b1);
        idle(10);
        checks++; if (acc_q.size() - a0 !== 1) begin failures++; $display("FAIL framing_next_count got=%0d want=1", acc_q.size() - a0); end
        else begin
            checks++; if (acc_q[a0] !== 8'h81) begin failures++; $display("FAIL framing_next_data got=%0h want=81", acc_q[a0]); end
        end
    endtask

    task automatic test_overrun;
        int a0 = acc_q.size(), o0 = ov_cnt;
        data_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        idle(10);
        send_frame(8'h22, 1'b1);
        idle(10);
        checks++; if (data !== 8'h11) begin failures++; $display("FAIL overrun_hold got=%0h want=11", data); end
        checks++; if (data_valid !== 1'b1) begin failures++; $display("FAIL overrun_valid got=%0b want=1", data_valid); end
        checks++; if (ov_cnt - o0 !== 1) begin failures++; $display("FAIL overrun_pulse got=%0d want=1", ov_cnt - o0); end
        data_ready = 1'b1;
        idle(1);
        checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL overrun_drop got=%0b want=0", data_valid); end
        checks++; if (acc_q.size() - a0 !== 1) begin failures++; $display("FAIL overrun_accept_count got=%0d want=1", acc_q.size() - a0); end
        else begin
            checks++; if (acc_q[a0] !== 8'h11) begin failures++; $display("FAIL overrun_accept_data got=%0h want=11", acc_q[a0]); end
        end
    endtask

    task automatic test_back_to_back;
        int a0 = acc_q.size(), o0 = ov_cnt, s1, lat, c0, l0;
        data_ready = 1'b0;
        idle(1);
        s1 = cyc + 1;
        send_frame(8'h55, 1'b1);
        idle(10);
        lat = rise_cyc - s1;
        checks++; if (data_valid !== 1'b1 || data !== 8'h55) begin failures++; $display("FAIL b2b_first got=%0b/%0h want=1/55", data_valid, data); end
        c0 = cyc;
        l0 = vlo_cnt;
        fork
            send_frame(8'hAA, 1'b1);
            begin
                while (cyc != c0 + lat) idle(1);
                data_ready = 1'b1;
                idle(1);
                data_ready = 1'b0;
            end
        join
        idle(10);
        checks++; if (data !== 8'hAA) begin failures++; $display("FAIL b2b_data got=%0h want=aa", data); end
        checks++; if (data_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%0b want=1", data_valid); end
        checks++; if (vlo_cnt - l0 !== 0) begin failures++; $display("FAIL b2b_valid_gap got=%0d want=0", vlo_cnt - l0); end
        checks++; if (ov_cnt - o0 !== 0) begin failures++; $display("FAIL b2b_overrun got=%0d want=0", ov_cnt - o0); end
        checks++; if (acc_q.size() - a0 !== 1 || acc_q[acc_q.size()-1] !== 8'h55) begin failures++; $display("FAIL b2b_accept got=%0d want=1 byte 55", acc_q.size() - a0); end
        data_ready = 1'b1;
        idle(2);
    endtask

    task automatic test_reset_midframe;
        int a0 = acc_q.size(), f0 = fr_cnt, o0 = ov_cnt;
        data_ready = 1'b1;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                idle(CPB * 5 + CPB / 2);
                n_reset = 1'b0;
                idle(2);
                checks++; if (data !== 8'h00 || data_valid !== 1'b0) begin failures++; $display("FAIL midreset_hold got=%0b/%0h want=0/0", data_valid, data); end
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%0b want=0", busy); end
                checks++; if (framing_err !== 1'b0 || overrun_err !== 1'b0) begin failures++; $display("FAIL midreset_errs got=%0b%0b want=00", framing_err, overrun_err); end
                n_reset = 1'b1;
            end
        join
        idle(20);
        send_frame(8'h0F, 1'b1);
        idle(10);
        checks++; if (acc_q.size() - a0 !== 1) begin failures++; $display("FAIL midreset_count got=%0d want=1", acc_q.size() - a0); end
        else begin
            checks++; if (acc_q[a0] !== 8'h0F) begin failures++; $display("FAIL midreset_data got=%0h want=0f", acc_q[a0]); end
        end
        checks++; if ((fr_cnt - f0) + (ov_cnt - o0) !== 0) begin failures++; $display("FAIL midreset_errs_after got=%0d want=0", (fr_cnt - f0) + (ov_cnt - o0)); end
    endtask

    task automatic test_random;
        logic [7:0] exp_q[$];
        int exp_fr = 0;
        int a0 = acc_q.size(), f0 = fr_cnt, o0 = ov_cnt;
        logic [7:0] b;
        logic bad;
        data_ready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            b = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 3) == 0);
            if (bad) exp_fr++; else exp_q.push_back(b);
            send_frame(b, !bad);
            idle($urandom_range(8, 40));
        end
        idle(10);
        checks++; if (acc_q.size() - a0 !== exp_q.size()) begin failures++; $display("FAIL random_count got=%0d want=%0d", acc_q.size() - a0, exp_q.size()); end
        else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++; if (acc_q[a0 + i] !== exp_q[i]) begin failures++; $display("FAIL random_byte%0d got=%0h want=%0h", i, acc_q[a0 + i], exp_q[i]); end
            end
        end
        checks++; if (fr_cnt - f0 !== exp_fr) begin failures++; $display("FAIL random_framing got=%0d want=%0d", fr_cnt - f0, exp_fr); end
        checks++; if (ov_cnt - o0 !== 0) begin failures++; $display("FAIL random_overrun got=%0d want=0", ov_cnt - o0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_framing();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
